// File: rtl/mem_debug_dumper.sv
// Streams a snapshot of the flattened data memory out one byte at a time over a
// valid/ready byte interface: slots in ascending order, bytes MSB first.
module mem_debug_dumper #(
  parameter int IO_BUS_SIZE   = 32,
  parameter int MEM_ADDR_SIZE = 5
) (
  input  logic                                         i_clk,
  input  logic                                         i_reset,
  input  logic                                         i_start,
  input  logic [(2**MEM_ADDR_SIZE)*IO_BUS_SIZE-1:0]    i_bus_debug,
  input  logic                                         i_tx_ready,
  output logic [7:0]                                   o_data,
  output logic                                         o_valid,
  output logic                                         o_busy,
  output logic                                         o_done
);

  localparam int DEPTH = 2**MEM_ADDR_SIZE;
  localparam int BYTES = IO_BUS_SIZE / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [BCW-1:0]           LAST_BYTE = BCW'(BYTES - 1);
  localparam logic [MEM_ADDR_SIZE-1:0] LAST_SLOT = '1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Viewing the bus as [slot][lane][byte] makes lane BYTES-1 the slot's top byte.
  logic [DEPTH-1:0][BYTES-1:0][7:0] bus_view;
  logic [DEPTH-1:0][BYTES-1:0][7:0] snap;

  logic [1:0]               state;
  logic [MEM_ADDR_SIZE-1:0] slot_cnt;
  logic [BCW-1:0]           byte_cnt;

  logic                     last_byte;
  logic                     last_slot;
  logic                     tx_fire;
  logic [MEM_ADDR_SIZE-1:0] nxt_slot;
  logic [BCW-1:0]           nxt_byte;
  logic [7:0]               nxt_data;

  assign bus_view  = i_bus_debug;
  assign last_byte = (byte_cnt == LAST_BYTE);
  assign last_slot = (slot_cnt == LAST_SLOT);
  assign tx_fire   = o_valid && i_tx_ready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    nxt_byte = byte_cnt + 1'b1;
    nxt_slot = slot_cnt;
    if (last_byte) begin
      nxt_byte = '0;
      nxt_slot = slot_cnt + 1'b1;
    end
    nxt_data = snap[nxt_slot][LAST_BYTE - nxt_byte];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= ST_IDLE;
      // NOTE: the snapshot is wide but is cleared on reset as well, so no stale
      // memory contents survive a reset.
      snap     <= '0;
      slot_cnt <= '0;
      byte_cnt <= '0;
      o_data   <= 8'h00;
      o_valid  <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            snap     <= bus_view;
            slot_cnt <= '0;
            byte_cnt <= '0;
            o_data   <= bus_view[0][BYTES-1];
            o_valid  <= 1'b1;
            o_busy   <= 1'b1;
            state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (tx_fire) begin
            if (last_byte && last_slot) begin
              o_valid <= 1'b0;
              o_done  <= 1'b1;
              state   <= ST_DONE;
            end else begin
              byte_cnt <= nxt_byte;
              slot_cnt <= nxt_slot;
              o_data   <= nxt_data;
            end
          end
        end
        ST_DONE: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
          o_done  <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_debug_dumper.sv
// Randomized self-checking bench for mem_debug_dumper; expected byte streams come
// from a queue built directly from the slot values latched at the start request.
module tb_mem_debug_dumper;

  localparam int W     = 32;
  localparam int A     = 5;
  localparam int DEPTH = 2**A;
  localparam int NB    = DEPTH * W / 8;

  logic                 i_clk = 1'b0;
  logic                 i_reset = 1'b1;
  logic                 i_start = 1'b0;
  logic [DEPTH*W-1:0]   i_bus_debug = '0;
  logic                 i_tx_ready = 1'b0;
  logic [7:0]           o_data;
  logic                 o_valid;
  logic                 o_busy;
  logic                 o_done;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  logic [W-1:0] slots [DEPTH];
  logic [7:0]   exp_q [$];

  mem_debug_dumper #(.IO_BUS_SIZE(W), .MEM_ADDR_SIZE(A)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_bus_debug (i_bus_debug),
    .i_tx_ready  (i_tx_ready),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Reference: slots ascending, each slot emitted most significant byte first.
  task automatic load_slots_and_model();
    exp_q.delete();
    for (int k = 0; k < DEPTH; k++) begin
      i_bus_debug[k*W +: W] = slots[k];
      for (int j = 0; j < W/8; j++)
        exp_q.push_back(8'(slots[k] >> (W - 8 - 8*j)));
    end
  endtask

  task automatic fill_pattern();
    for (int k = 0; k < DEPTH; k++) slots[k] = 32'hA0B0C000 | 32'(k);
  endtask

  task automatic fill_random();
    for (int k = 0; k < DEPTH; k++) slots[k] = $urandom;
  endtask

  // rmode: 0 = ready always high, 1 = ready pattern 1,0,0, 2 = random ready
  task automatic do_dump(input string name, input int rmode, input bit overwrite,
                         input bit busy_starts, input bit check_timing);
    logic [7:0] got_q [$];
    int         dones = 0;
    int         t_edge;
    int         done_at = 0;
    bit         done_seen = 0;
    bit         held_v = 0;
    logic [7:0] held_d = 8'h00;
    bit         rdy;

    load_slots_and_model();
    @(negedge i_clk);
    i_start    = 1'b1;
    i_tx_ready = 1'b1;
    @(negedge i_clk);
    t_edge = cyc;
    for (int i = 0; i < 4000 && !done_seen; i++) begin
      if (i > 0) @(negedge i_clk);
      i_start = busy_starts && (got_q.size() == 10 || o_done);
      if (i == 0 && overwrite) i_bus_debug = '1;
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (i % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      i_tx_ready = rdy;
      if (held_v) begin
        check({name, ":hold_valid"}, 32'(o_valid), 32'd1);
        check({name, ":hold_data"}, 32'(o_data), 32'(held_d));
      end
      if (o_done) begin
        dones++;
        done_seen = 1;
        done_at   = cyc;
        check({name, ":done_valid"}, 32'(o_valid), 32'd0);
        check({name, ":done_busy"}, 32'(o_busy), 32'd1);
      end else if (!o_valid) begin
        check({name, ":send_valid"}, 32'(o_valid), 32'd1);
      end
      held_v = o_valid && !rdy;
      held_d = o_data;
      if (o_valid && rdy) got_q.push_back(o_data);
    end
    if (!done_seen) check({name, ":done_timeout"}, 32'd0, 32'd1);

    @(negedge i_clk);
    i_start = 1'b0;
    check({name, ":idle_busy"}, 32'(o_busy), 32'd0);
    check({name, ":idle_valid"}, 32'(o_valid), 32'd0);
    check({name, ":idle_done"}, 32'(o_done), 32'd0);
    check({name, ":done_pulses"}, 32'(dones), 32'd1);
    if (check_timing) check({name, ":done_latency"}, 32'(done_at - t_edge), 32'(NB));
    check({name, ":byte_count"}, 32'(got_q.size()), 32'(NB));
    for (int j = 0; j < NB; j++)
      check({name, ":byte"}, (j < got_q.size()) ? 32'(got_q[j]) : 32'hDEAD, 32'(exp_q[j]));
  endtask

  initial begin
    // Reset with ready high: nothing may be offered.
    i_reset    = 1'b1;
    i_tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      if (i > 0) begin
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_data", 32'(o_data), 32'h00);
      end
    end
    i_reset = 1'b0;
    @(negedge i_clk);
    check("idle_valid", 32'(o_valid), 32'd0);
    check("idle_busy", 32'(o_busy), 32'd0);

    fill_pattern();
    do_dump("full", 0, 1'b0, 1'b0, 1'b1);

    fill_pattern();
    do_dump("bp", 1, 1'b0, 1'b0, 1'b0);

    fill_pattern();
    do_dump("snap", 0, 1'b1, 1'b0, 1'b1);

    fill_pattern();
    do_dump("busy_start", 0, 1'b0, 1'b1, 1'b1);

    for (int r = 0; r < 3; r++) begin
      fill_random();
      do_dump("rand", 2, 1'b1, 1'b0, 1'b0);
    end

    // Reset after 50 accepted bytes aborts the dump.
    begin
      int acc = 0;
      fill_pattern();
      load_slots_and_model();
      @(negedge i_clk);
      i_start    = 1'b1;
      i_tx_ready = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      for (int i = 0; i < 200 && acc < 50; i++) begin
        if (o_valid) acc++;
        @(negedge i_clk);
      end
      check("abort_accepted", 32'(acc), 32'd50);
      check("abort_data_before", 32'(o_data), 32'(exp_q[50]));
      i_reset = 1'b1;
      @(negedge i_clk);
      check("abort_valid", 32'(o_valid), 32'd0);
      check("abort_busy", 32'(o_busy), 32'd0);
      check("abort_done", 32'(o_done), 32'd0);
      i_reset = 1'b0;
    end
    fill_pattern();
    do_dump("restart", 0, 1'b0, 1'b0, 1'b1);

    // Held start re-triggers a fresh dump on the first idle cycle after done.
    begin
      bit seen = 0;
      fill_random();
      load_slots_and_model();
      @(negedge i_clk);
      i_start    = 1'b1;
      i_tx_ready = 1'b1;
      for (int i = 0; i < 400 && !seen; i++) begin
        @(negedge i_clk);
        seen = o_done;
      end
      check("held_done_seen", 32'(seen), 32'd1);
      @(negedge i_clk);
      check("held_idle_busy", 32'(o_busy), 32'd0);
      @(negedge i_clk);
      check("held_retrig_busy", 32'(o_busy), 32'd1);
      check("held_retrig_valid", 32'(o_valid), 32'd1);
      check("held_retrig_data", 32'(o_data), 32'(exp_q[0]));
      i_start = 1'b0;
      i_reset = 1'b1;
      @(negedge i_clk);
      i_reset = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
